apb_slave_regbank: RTL and testbench



---
 rtl/apb_slave_regbank_if.sv | 26 ++
 rtl/apb_slave_regbank.sv | 125 ++++++++++++
 tb/tb_apb_slave_regbank.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle for apb_slave_regbank.
// The master modport drives the request; the slave modport returns the response.
interface apb_slave_regbank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W/8-1:0] PSTRB;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB register bank with byte strobes and programmable wait states.
// Define APB_SLV_PSLVERR_EN to flag out-of-window accesses on PSLVERR.
module apb_slave_regbank #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h7000_0000,
    parameter int          WAIT_STATES = 1
) (
    input logic PCLK,
    input logic PRSTn,
    apb_slave_regbank_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                capture;
    logic                commit;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [ADDR_W-1:0]   offset;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                ready;

    // Decode works on the captured address so ACCESS-phase bus changes are ignored
    assign offset   = addr_q - ADDR_W'(BASE_ADDR);
    assign in_range = offset < ADDR_W'(NUM_REGS * 4);
    assign idx      = offset[2 +: IDX_W];
    assign ready    = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_ff @(posedge PCLK) begin
        if (!PRSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                unique case (1'b1)
                    !bus.PSEL: begin
                        state_d = IDLE;
                    end
                    bus.PSEL && !bus.PENABLE: begin
                        capture = 1'b1;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                    bus.PSEL && bus.PENABLE && (cnt_q != 4'd0): begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    bus.PSEL && bus.PENABLE && (cnt_q == 4'd0): begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRSTn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (capture) begin
            addr_q  <= bus.PADDR;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRSTn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (commit && write_q && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    regs_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.PREADY = ready;
    assign bus.PRDATA = (ready && !write_q && in_range) ? regs_q[idx] : '0;

`ifdef APB_SLV_PSLVERR_EN
    assign bus.PSLVERR = ready && !in_range;
`else
    assign bus.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: one instance with 1 wait state,
// one with 0 wait states, sharing a single APB driver.
module tb_apb_slave_regbank;
    logic        PCLK = 1'b0;
    logic        PRSTn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        sel = 1'b0;

    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_chk = 0;
    int n_pass = 0;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 PCLK = ~PCLK;

    apb_slave_regbank_if #(.ADDR_W(32), .DATA_W(32)) if_ws1 ();
    apb_slave_regbank_if #(.ADDR_W(32), .DATA_W(32)) if_ws0 ();

    assign if_ws1.PSEL    = psel & ~sel;
    assign if_ws0.PSEL    = psel & sel;
    assign if_ws1.PENABLE = penable;
    assign if_ws0.PENABLE = penable;
    assign if_ws1.PWRITE  = pwrite;
    assign if_ws0.PWRITE  = pwrite;
    assign if_ws1.PADDR   = paddr;
    assign if_ws0.PADDR   = paddr;
    assign if_ws1.PWDATA  = pwdata;
    assign if_ws0.PWDATA  = pwdata;
    assign if_ws1.PSTRB   = pstrb;
    assign if_ws0.PSTRB   = pstrb;

    assign prdata  = sel ? if_ws0.PRDATA  : if_ws1.PRDATA;
    assign pready  = sel ? if_ws0.PREADY  : if_ws1.PREADY;
    assign pslverr = sel ? if_ws0.PSLVERR : if_ws1.PSLVERR;

    apb_slave_regbank #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(16),
        .BASE_ADDR(32'h7000_0000), .WAIT_STATES(1)
    ) u_ws1 (
        .PCLK(PCLK),
        .PRSTn(PRSTn),
        .bus(if_ws1.slave)
    );

    apb_slave_regbank #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(16),
        .BASE_ADDR(32'h7000_0000), .WAIT_STATES(0)
    ) u_ws0 (
        .PCLK(PCLK),
        .PRSTn(PRSTn),
        .bus(if_ws0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    // Bus values are scrambled during ACCESS; the DUT must use the setup values
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err,
                            output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge PCLK); #1;
        penable = 1'b1;
        paddr = ~addr; pwdata = ~data; pstrb = ~strb;
        waits = 0;
        while (!pready && waits < 32) begin
            @(posedge PCLK); #1;
            waits++;
        end
        if (waits >= 32) chk("pready_timeout", 32'(waits), 32'd0);
        rdata = prdata;
        err = pslverr;
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic oor);
        logic [31:0] rd_v;
        logic        err;
        int          waits;
        apb_xfer(1'b1, addr, data, strb, rd_v, err, waits);
        chk({tag, "_waits"}, 32'(waits), sel ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(ERR_EN & oor));
        chk({tag, "_wrdata0"}, rd_v, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp, input logic oor);
        logic [31:0] rd_v;
        logic        err;
        int          waits;
        apb_xfer(1'b0, addr, 32'h5A5A_5A5A, 4'hF, rd_v, err, waits);
        chk({tag, "_waits"}, 32'(waits), sel ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(ERR_EN & oor));
        chk({tag, "_data"}, rd_v, exp);
    endtask

    initial begin
        PRSTn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_pready", 32'(pready), 32'd0);
            chk("rst_prdata", prdata, 32'h0);
            chk("rst_pslverr", 32'(pslverr), 32'd0);
        end
        sel = 1'b0;
        PRSTn = 1'b1;
        @(posedge PCLK); #1;

        for (int r = 0; r < 16; r++) begin
            rd("rst_reg", 32'h7000_0000 + 32'(r * 4), 32'h0, 1'b0);
        end

        wr("full_wr", 32'h7000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd("full_rd", 32'h7000_0004, 32'hDEAD_BEEF, 1'b0);
        rd("alias_rd", 32'h7000_0007, 32'hDEAD_BEEF, 1'b0);

        wr("strb_base", 32'h7000_0008, 32'h1122_3344, 4'hF, 1'b0);
        wr("strb_wr", 32'h7000_000B, 32'hAABB_CCDD, 4'b0010, 1'b0);
        rd("strb_rd", 32'h7000_0008, 32'h1122_CC44, 1'b0);
        wr("strb0_wr", 32'h7000_0004, 32'h0123_4567, 4'h0, 1'b0);
        rd("strb0_rd", 32'h7000_0004, 32'hDEAD_BEEF, 1'b0);
        wr("strb_hi", 32'h7000_0008, 32'hFF00_0000, 4'b1000, 1'b0);
        rd("strb_hi_rd", 32'h7000_0008, 32'hFF22_CC44, 1'b0);

        sel = 1'b1;
        wr("b2b_wr", 32'h7000_0000, 32'h0000_000A, 4'hF, 1'b0);
        rd("b2b_rd", 32'h7000_0000, 32'h0000_000A, 1'b0);
        wr("b2b_wr3c", 32'h7000_003C, 32'hCAFE_F00D, 4'hF, 1'b0);
        rd("b2b_rd3c", 32'h7000_003C, 32'hCAFE_F00D, 1'b0);
        @(posedge PCLK); #1;

        sel = 1'b0;
        wr("abort_pre", 32'h7000_000C, 32'h0102_0304, 4'hF, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h7000_000C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        chk("abort_wait", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_idle", 32'(pready), 32'd0);
        rd("abort_rd", 32'h7000_000C, 32'h0102_0304, 1'b0);

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h7000_000C; pwdata = 32'hAAAA_AAAA; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        PRSTn = 1'b0;
        @(posedge PCLK); #1;
        chk("midrst_pready", 32'(pready), 32'd0);
        chk("midrst_prdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        PRSTn = 1'b1;
        @(posedge PCLK); #1;
        rd("midrst_r3", 32'h7000_000C, 32'h0, 1'b0);
        rd("midrst_r1", 32'h7000_0004, 32'h0, 1'b0);
        sel = 1'b1;
        rd("midrst_ws0_r0", 32'h7000_0000, 32'h0, 1'b0);
        sel = 1'b0;

        wr("oor_wr", 32'h7000_0040, 32'h1234_5678, 4'hF, 1'b1);
        rd("oor_r0", 32'h7000_0000, 32'h0, 1'b0);
        rd("oor_rd", 32'h7000_0040, 32'h0, 1'b1);
        wr("oor_lo_wr", 32'h6FFF_FFFC, 32'h8765_4321, 4'hF, 1'b1);
        rd("oor_r15", 32'h7000_003C, 32'h0, 1'b0);
        wr("in_r15", 32'h7000_003C, 32'h0BAD_F00D, 4'hF, 1'b0);
        rd("oor_rd_hit", 32'h7000_007C, 32'h0, 1'b1);
        rd("in_r15_rd", 32'h7000_003C, 32'h0BAD_F00D, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
